avalon_burst_mem_responder: RTL and testbench

- Avalon-MM burst slave backed by an inferred on-chip word RAM.
- Serves the data cache's line fills (burst read), its dirty-line write-backs (burst write), and its single-beat uncached accesses.
- Drives the master-side handshake signals the cache consumes: av_waitrequest, av_read_data_valid, av_read_data_wait and write_ready_n.
- Used as the memory model in SoC simulation and as a scratch RAM on FPGA.

---
 rtl/avalon_burst_mem_responder.sv | 205 ++++++++++++++++++++
 tb/tb_avalon_burst_mem_responder.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/avalon_burst_mem_responder.sv
// Avalon-MM burst slave over an on-chip word RAM: burst/single reads and writes
// with programmable read latency and optional periodic write-beat stalls.
//
// Ports:
//   clk, resetn          clock, synchronous active-low reset
//   av_address           byte address, word index = av_address[ADDR_W+1:2]
//   av_read, av_write    command strobes (av_write also marks each write beat)
//   av_burstcount        beats per burst, 0 means 1
//   av_writedata         write beat data
//   av_waitrequest       command/beat not accepted this cycle
//   av_read_data_valid   av_reddata carries a read beat
//   av_reddata           read beat data, holds its value between bursts
//   av_read_data_wait    read burst outstanding
//   write_ready_n        high while any command is in flight
//   protocol_err         sticky, read and write seen together in IDLE
module avalon_burst_mem_responder #(
   parameter int DEPTH        = 4096,
   parameter int ADDR_W       = 12,
   parameter int READ_LATENCY = 2,
   parameter int WAIT_EVERY   = 0
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic [31:0] av_address,
   input  logic        av_read,
   input  logic        av_write,
   input  logic [4:0]  av_burstcount,
   input  logic [31:0] av_writedata,
   output logic        av_waitrequest,
   output logic        av_read_data_valid,
   output logic [31:0] av_reddata,
   output logic        av_read_data_wait,
   output logic        write_ready_n,
   output logic        protocol_err
);

   typedef enum logic [2:0] {
      IDLE, WR_BURST, WR_COMMIT, RD_LAT, RD_BURST
   } state_t;

   localparam int IW = 16;
   localparam logic [IW-1:0]     WAIT_N = IW'(WAIT_EVERY);
   localparam logic [IW-1:0]     INJ_1  = IW'(1);
   localparam logic [ADDR_W-1:0] ONE    = ADDR_W'(1);
   // RD_LAT lasts READ_LATENCY-1 cycles; the counter exits at zero
   localparam logic [2:0] LAT_INIT =
      3'((READ_LATENCY >= 2) ? READ_LATENCY - 2 : 0);

   state_t state, state_n;

   logic [31:0]       mem [DEPTH];
   logic [ADDR_W-1:0] ptr;
   logic [ADDR_W-1:0] widx;
   logic [4:0]        rem;
   logic [4:0]        n_beats;
   logic [2:0]        lat;
   logic [IW-1:0]     inj_cnt;
   logic [IW-1:0]     inj_nxt;
   logic              stall;
   logic [31:0]       rd_q;

   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic              beat;
   logic              fetch;
   logic [ADDR_W-1:0] fetch_addr;
   logic              perr_set;
   logic              unused_addr;

   assign widx        = av_address[ADDR_W+1:2];
   assign unused_addr = ^{av_address[31:ADDR_W+2], av_address[1:0]};
   assign n_beats     = (av_burstcount == 5'd0) ? 5'd1 : av_burstcount;
   // beat 0 restarts the stall count from zero
   assign inj_nxt     = ((state == IDLE) ? '0 : inj_cnt) + INJ_1;
   assign av_reddata  = rd_q;

   always_ff @(posedge clk) begin
      if (!resetn)
         state <= IDLE;
      else
         state <= state_n;
   end

   always_comb begin
      state_n            = state;
      wr_en              = 1'b0;
      wr_addr            = ptr + ONE;
      beat               = 1'b0;
      fetch              = 1'b0;
      fetch_addr         = ptr;
      perr_set           = 1'b0;
      av_waitrequest     = 1'b0;
      av_read_data_valid = 1'b0;
      av_read_data_wait  = 1'b0;
      write_ready_n      = 1'b1;
      unique case (state)
         IDLE: begin
            write_ready_n = 1'b0;
            if (av_write) begin
               wr_en    = 1'b1;
               wr_addr  = widx;
               beat     = 1'b1;
               perr_set = av_read;
               state_n  = (n_beats == 5'd1) ? WR_COMMIT : WR_BURST;
            end else if (av_read) begin
               if (READ_LATENCY <= 1) begin
                  state_n    = RD_BURST;
                  fetch      = 1'b1;
                  fetch_addr = widx;
               end else begin
                  state_n = RD_LAT;
               end
            end
         end
         WR_BURST: begin
            av_waitrequest = stall;
            if (av_write && !stall) begin
               wr_en = 1'b1;
               beat  = 1'b1;
               if (rem == 5'd1)
                  state_n = WR_COMMIT;
            end
         end
         WR_COMMIT: begin
            av_waitrequest = 1'b1;
            state_n        = IDLE;
         end
         RD_LAT: begin
            av_waitrequest    = 1'b1;
            av_read_data_wait = 1'b1;
            if (lat == 3'd0) begin
               state_n = RD_BURST;
               fetch   = 1'b1;
            end
         end
         RD_BURST: begin
            av_waitrequest     = 1'b1;
            av_read_data_wait  = 1'b1;
            av_read_data_valid = 1'b1;
            if (rem == 5'd1)
               state_n = IDLE;
            else
               fetch = 1'b1;
         end
         default: state_n = IDLE;
      endcase
   end

   // RAM contents survive reset
   always_ff @(posedge clk) begin
      if (wr_en)
         mem[wr_addr] <= av_writedata;
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         ptr          <= '0;
         rem          <= '0;
         lat          <= '0;
         inj_cnt      <= '0;
         stall        <= 1'b0;
         rd_q         <= '0;
         protocol_err <= 1'b0;
      end else begin
         stall <= 1'b0;
         if (perr_set)
            protocol_err <= 1'b1;
         unique case (state)
            IDLE: begin
               if (av_write) begin
                  ptr <= widx;
                  rem <= n_beats - 5'd1;
               end else if (av_read) begin
                  ptr <= widx;
                  rem <= n_beats;
                  lat <= LAT_INIT;
               end
            end
            WR_BURST: begin
               if (beat) begin
                  ptr <= ptr + ONE;
                  rem <= rem - 5'd1;
               end
            end
            RD_LAT:   lat <= lat - 3'd1;
            RD_BURST: rem <= rem - 5'd1;
            default: ;
         endcase
         // data is fetched one cycle ahead so av_reddata is a register
         if (fetch) begin
            rd_q <= mem[fetch_addr];
            ptr  <= fetch_addr + ONE;
         end
         if (beat && (WAIT_EVERY > 0)) begin
            if (inj_nxt == WAIT_N) begin
               inj_cnt <= '0;
               stall   <= 1'b1;
            end else begin
               inj_cnt <= inj_nxt;
            end
         end
      end
   end

endmodule

// File: tb/tb_avalon_burst_mem_responder.sv
// Bench for avalon_burst_mem_responder: one instance without stall injection
// and one with WAIT_EVERY=4, read data checked against a scoreboard queue.
module tb_avalon_burst_mem_responder;

   localparam int DEPTH = 4096;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        sel = 1'b0;
   logic [31:0] av_address = '0;
   logic        av_read = 1'b0;
   logic        av_write = 1'b0;
   logic [4:0]  av_burstcount = '0;
   logic [31:0] av_writedata = '0;

   logic        m_wr, m_vld, m_rdw, m_wrn, m_perr;
   logic [31:0] m_data;
   logic        w_wr, w_vld, w_rdw, w_wrn, w_perr;
   logic [31:0] w_data;

   logic        waitreq, vld, rdw, wrn, perr;
   logic [31:0] rdata;

   int vectors = 0;
   int miscompares = 0;

   logic [31:0] model [DEPTH];
   logic [31:0] wdata [32];
   logic [31:0] exp_q [$];
   logic [31:0] exp_d;

   int          wrn_hi, last_c, idle_c, first, nv, rdw_hi, lastv;
   logic [31:0] wmask;

   always #5 clk = ~clk;

   avalon_burst_mem_responder #(.READ_LATENCY(2), .WAIT_EVERY(0)) dut (
      .clk(clk), .resetn(resetn), .av_address(av_address),
      .av_read(av_read & ~sel), .av_write(av_write & ~sel),
      .av_burstcount(av_burstcount), .av_writedata(av_writedata),
      .av_waitrequest(m_wr), .av_read_data_valid(m_vld),
      .av_reddata(m_data), .av_read_data_wait(m_rdw),
      .write_ready_n(m_wrn), .protocol_err(m_perr));

   avalon_burst_mem_responder #(.READ_LATENCY(2), .WAIT_EVERY(4)) dut_w (
      .clk(clk), .resetn(resetn), .av_address(av_address),
      .av_read(av_read & sel), .av_write(av_write & sel),
      .av_burstcount(av_burstcount), .av_writedata(av_writedata),
      .av_waitrequest(w_wr), .av_read_data_valid(w_vld),
      .av_reddata(w_data), .av_read_data_wait(w_rdw),
      .write_ready_n(w_wrn), .protocol_err(w_perr));

   assign waitreq = sel ? w_wr   : m_wr;
   assign vld     = sel ? w_vld  : m_vld;
   assign rdata   = sel ? w_data : m_data;
   assign rdw     = sel ? w_rdw  : m_rdw;
   assign wrn     = sel ? w_wrn  : m_wrn;
   assign perr    = sel ? w_perr : m_perr;

   // every valid read beat is matched against the oldest expected word
   always @(negedge clk) begin
      if (vld) begin
         vectors++;
         if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL rd_data got %h exp none", rdata);
         end else begin
            exp_d = exp_q.pop_front();
            if (rdata !== exp_d) begin
               miscompares++;
               $display("FAIL rd_data got %h exp %h", rdata, exp_d);
            end
         end
      end
   end

   task automatic drive_write(input logic [31:0] addr, input logic [4:0] bc,
                              input int gap_at, input int gap_len,
                              output int o_wrn, output logic [31:0] o_mask,
                              output int o_last, output int o_idle);
      int n, b, gap;
      int wi;
      n = (bc == 5'd0) ? 1 : int'(bc);
      wi = int'(addr[13:2]);
      o_wrn = 0; o_mask = '0; o_last = -1; o_idle = -1; gap = 0;
      @(negedge clk);
      av_address = addr; av_burstcount = bc;
      av_write = 1'b1; av_writedata = wdata[0];
      model[wi] = wdata[0];
      b = 1; o_last = 0;
      for (int cyc = 1; cyc < 200; cyc++) begin
         @(negedge clk);
         av_address = 32'hFFFF_FFFF; av_burstcount = 5'd1;
         if (wrn) o_wrn++;
         if (waitreq) o_mask[b] = 1'b1;
         if (!wrn) begin
            o_idle = cyc;
            av_write = 1'b0;
            break;
         end
         if (b < n && !(b == gap_at + 1 && gap < gap_len)) begin
            av_write = 1'b1; av_writedata = wdata[b];
            if (!waitreq) begin
               model[(wi + b) % DEPTH] = wdata[b];
               b++;
               o_last = cyc;
            end
         end else begin
            if (b < n) gap++;
            av_write = 1'b0;
         end
      end
      av_write = 1'b0;
   endtask

   task automatic drive_read(input logic [31:0] addr, input logic [4:0] bc,
                             output int o_first, output int o_nv,
                             output int o_rdw, output int o_lastv);
      int n, wi;
      n = (bc == 5'd0) ? 1 : int'(bc);
      wi = int'(addr[13:2]);
      o_first = -1; o_nv = 0; o_rdw = 0; o_lastv = -1;
      @(negedge clk);
      av_address = addr; av_burstcount = bc; av_read = 1'b1;
      for (int k = 0; k < n; k++) exp_q.push_back(model[(wi + k) % DEPTH]);
      for (int cyc = 1; cyc < 100; cyc++) begin
         @(negedge clk);
         av_read = 1'b0;
         if (vld) begin
            if (o_first < 0) o_first = cyc;
            o_nv++;
            o_lastv = cyc;
         end
         if (rdw) o_rdw++;
         if (!wrn && !rdw) break;
      end
      av_read = 1'b0;
   endtask

   task automatic test_reset;
      resetn = 1'b0;
      repeat (3) @(negedge clk);
      vectors++;
      if ({m_wr, m_vld, m_data, m_rdw, m_wrn, m_perr} !== 37'd0) begin
         miscompares++;
         $display("FAIL reset_main got %h exp 0",
                  {m_wr, m_vld, m_data, m_rdw, m_wrn, m_perr});
      end
      vectors++;
      if ({w_wr, w_vld, w_data, w_rdw, w_wrn, w_perr} !== 37'd0) begin
         miscompares++;
         $display("FAIL reset_wait got %h exp 0",
                  {w_wr, w_vld, w_data, w_rdw, w_wrn, w_perr});
      end
      resetn = 1'b1;
      repeat (2) @(negedge clk);
      vectors++;
      if ({waitreq, wrn} !== 2'b00) begin
         miscompares++;
         $display("FAIL idle_ready got %b exp 00", {waitreq, wrn});
      end
   endtask

   task automatic test_burst_rw;
      for (int i = 0; i < 16; i++) wdata[i] = 32'hA0 + i;
      drive_write(32'h0000_1000, 5'd16, -1, 0, wrn_hi, wmask, last_c, idle_c);
      vectors++;
      if (wmask !== 32'h0001_0000) begin
         miscompares++;
         $display("FAIL burst_wr_wait got %h exp 00010000", wmask);
      end
      vectors++;
      if (wrn_hi !== 16) begin
         miscompares++;
         $display("FAIL burst_wr_busy got %0d exp 16", wrn_hi);
      end
      vectors++;
      if (idle_c !== 17) begin
         miscompares++;
         $display("FAIL burst_wr_idle got %0d exp 17", idle_c);
      end
      drive_read(32'h0000_1000, 5'd16, first, nv, rdw_hi, lastv);
      vectors++;
      if ({first, nv, lastv, rdw_hi} !== {32'd2, 32'd16, 32'd17, 32'd17}) begin
         miscompares++;
         $display("FAIL burst_rd first %0d n %0d last %0d wait %0d exp 2 16 17 17",
                  first, nv, lastv, rdw_hi);
      end
   endtask

   task automatic test_single;
      wdata[0] = 32'hDEAD_BEEF;
      drive_write(32'h0FFF_FFC4, 5'd1, -1, 0, wrn_hi, wmask, last_c, idle_c);
      vectors++;
      if ({wrn_hi, idle_c, wmask} !== {32'd1, 32'd2, 32'h2}) begin
         miscompares++;
         $display("FAIL single_wr busy %0d idle %0d mask %h exp 1 2 00000002",
                  wrn_hi, idle_c, wmask);
      end
      drive_read(32'h0FFF_FFC4, 5'd1, first, nv, rdw_hi, lastv);
      vectors++;
      if ({first, nv, rdw_hi} !== {32'd2, 32'd1, 32'd2}) begin
         miscompares++;
         $display("FAIL single_rd first %0d n %0d wait %0d exp 2 1 2",
                  first, nv, rdw_hi);
      end
   endtask

   task automatic test_write_gap;
      for (int i = 0; i < 16; i++) wdata[i] = 32'h5000 + i;
      drive_write(32'h0000_2400, 5'd16, 5, 3, wrn_hi, wmask, last_c, idle_c);
      vectors++;
      if ({wmask, last_c, idle_c, wrn_hi} !==
          {32'h0001_0000, 32'd18, 32'd20, 32'd19}) begin
         miscompares++;
         $display("FAIL gap_wr mask %h last %0d idle %0d busy %0d exp 00010000 18 20 19",
                  wmask, last_c, idle_c, wrn_hi);
      end
      drive_read(32'h0000_2400, 5'd16, first, nv, rdw_hi, lastv);
      vectors++;
      if (nv !== 16) begin
         miscompares++;
         $display("FAIL gap_rd_beats got %0d exp 16", nv);
      end
   endtask

   task automatic test_wrap;
      for (int i = 0; i < 4; i++) wdata[i] = 32'hC0DE_0000 + i;
      drive_write(32'hABCD_3FF8, 5'd4, -1, 0, wrn_hi, wmask, last_c, idle_c);
      vectors++;
      if (idle_c !== 5) begin
         miscompares++;
         $display("FAIL wrap_wr_idle got %0d exp 5", idle_c);
      end
      drive_read(32'h0000_3FF8, 5'd4, first, nv, rdw_hi, lastv);
      vectors++;
      if ({first, nv} !== {32'd2, 32'd4}) begin
         miscompares++;
         $display("FAIL wrap_rd first %0d n %0d exp 2 4", first, nv);
      end
   endtask

   task automatic test_bc0;
      wdata[0] = 32'h1234_5678;
      wdata[1] = 32'h9999_9999;
      drive_write(32'h0000_0100, 5'd0, -1, 0, wrn_hi, wmask, last_c, idle_c);
      vectors++;
      if ({wrn_hi, idle_c} !== {32'd1, 32'd2}) begin
         miscompares++;
         $display("FAIL bc0_wr busy %0d idle %0d exp 1 2", wrn_hi, idle_c);
      end
      drive_read(32'h0000_0100, 5'd0, first, nv, rdw_hi, lastv);
      vectors++;
      if ({nv, rdw_hi} !== {32'd1, 32'd2}) begin
         miscompares++;
         $display("FAIL bc0_rd n %0d wait %0d exp 1 2", nv, rdw_hi);
      end
   endtask

   task automatic test_wait_inject;
      sel = 1'b1;
      for (int i = 0; i < 16; i++) wdata[i] = 32'h70 + i;
      drive_write(32'h0000_2000, 5'd16, -1, 0, wrn_hi, wmask, last_c, idle_c);
      vectors++;
      if (wmask !== 32'h0001_1110) begin
         miscompares++;
         $display("FAIL inject_mask got %h exp 00011110", wmask);
      end
      vectors++;
      if ({last_c, idle_c} !== {32'd18, 32'd20}) begin
         miscompares++;
         $display("FAIL inject_timing last %0d idle %0d exp 18 20", last_c, idle_c);
      end
      drive_read(32'h0000_2000, 5'd16, first, nv, rdw_hi, lastv);
      vectors++;
      if (nv !== 16) begin
         miscompares++;
         $display("FAIL inject_rd_beats got %0d exp 16", nv);
      end
      sel = 1'b0;
   endtask

   task automatic test_protocol_err;
      @(negedge clk);
      av_address = 32'h0000_3000; av_burstcount = 5'd1;
      av_writedata = 32'h0BAD_F00D; av_read = 1'b1; av_write = 1'b1;
      model[32'h3000 >> 2] = 32'h0BAD_F00D;
      @(negedge clk);
      av_read = 1'b0; av_write = 1'b0;
      vectors++;
      if ({perr, wrn, rdw} !== 3'b110) begin
         miscompares++;
         $display("FAIL perr_set got %b exp 110", {perr, wrn, rdw});
      end
      repeat (3) @(negedge clk);
      drive_read(32'h0000_3000, 5'd1, first, nv, rdw_hi, lastv);
      vectors++;
      if ({perr, nv} !== {1'b1, 32'd1}) begin
         miscompares++;
         $display("FAIL perr_sticky perr %b n %0d exp 1 1", perr, nv);
      end
   endtask

   task automatic test_reset_mid;
      int cnt = 0;
      @(negedge clk);
      av_address = 32'h0000_1000; av_burstcount = 5'd16; av_read = 1'b1;
      for (int k = 0; k < 16; k++) exp_q.push_back(model[1024 + k]);
      for (int cyc = 0; cyc < 50; cyc++) begin
         @(negedge clk);
         av_read = 1'b0;
         if (vld) cnt++;
         if (cnt == 8) break;
      end
      vectors++;
      if (cnt !== 8) begin
         miscompares++;
         $display("FAIL rst_mid_reach got %0d exp 8", cnt);
      end
      resetn = 1'b0;
      @(negedge clk);
      vectors++;
      if ({m_wr, m_vld, m_data, m_rdw, m_wrn, m_perr} !== 37'd0) begin
         miscompares++;
         $display("FAIL rst_mid_out got %h exp 0",
                  {m_wr, m_vld, m_data, m_rdw, m_wrn, m_perr});
      end
      exp_q.delete();
      resetn = 1'b1;
      @(negedge clk);
      drive_read(32'h0000_1000, 5'd2, first, nv, rdw_hi, lastv);
      vectors++;
      if ({first, nv, perr} !== {32'd2, 32'd2, 1'b0}) begin
         miscompares++;
         $display("FAIL rst_mid_recover first %0d n %0d perr %b exp 2 2 0",
                  first, nv, perr);
      end
   endtask

   initial begin
      test_reset();
      test_burst_rw();
      test_single();
      test_write_gap();
      test_wrap();
      test_bc0();
      test_wait_inject();
      test_protocol_err();
      test_reset_mid();
      repeat (3) @(negedge clk);
      vectors++;
      if (exp_q.size() !== 0) begin
         miscompares++;
         $display("FAIL rd_outstanding got %0d exp 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
